// File: rtl/lcd1602_pkg.sv
// Shared types, opcode thresholds and DDRAM geometry for the HD44780-style
// LCD1602 bus responder.
package lcd1602_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_WAIT = 2'd2
  } lcd_state_e;

  // Instructions decode by their highest set bit, so each constant doubles
  // as the lower bound of its opcode range.
  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [7:0] OP_HOME    = 8'h02;
  localparam logic [7:0] OP_ENTRY   = 8'h04;
  localparam logic [7:0] OP_DISPLAY = 8'h08;
  localparam logic [7:0] OP_SHIFT   = 8'h10;
  localparam logic [7:0] OP_FUNCSET = 8'h20;
  localparam logic [7:0] OP_CGRAM   = 8'h40;
  localparam logic [7:0] OP_DDRAM   = 8'h80;

  localparam int         DDRAM_DEPTH = 80;
  localparam int         LINE_LEN    = 40;
  localparam logic [6:0] LINE0_BASE  = 7'h00;
  localparam logic [6:0] LINE1_BASE  = 7'h40;
  localparam logic [7:0] CHAR_SPACE  = 8'h20;
  localparam logic [6:0] IDX_NONE    = 7'h7F;

  function automatic logic ac_valid(input logic [6:0] a);
    return a[5:0] < 6'(LINE_LEN);
  endfunction

  // Invalid addresses map to an index past the array, which reads as a space.
  function automatic logic [6:0] ddram_index(input logic [6:0] a);
    if (!ac_valid(a)) return IDX_NONE;
    return (a[6] ? 7'(LINE_LEN) : 7'd0) + {1'b0, a[5:0]};
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a[5:0] >= 6'(LINE_LEN - 1)) return a[6] ? LINE0_BASE : LINE1_BASE;
      return a + 7'd1;
    end
    if (a == LINE0_BASE) return LINE1_BASE + 7'(LINE_LEN - 1);
    if (a == LINE1_BASE) return LINE0_BASE + 7'(LINE_LEN - 1);
    return a - 7'd1;
  endfunction

endpackage

// File: rtl/lcd1602_ddram.sv
// 80x8 display RAM: one write port, two registered read ports.
// Reads return the pre-write byte on an address collision.
module lcd1602_ddram
  import lcd1602_pkg::*;
(
  input  logic       clk,
  input  logic       we_i,
  input  logic [6:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [6:0] raddr_a_i,
  output logic [7:0] rdata_a_o,
  input  logic [6:0] raddr_b_i,
  output logic [7:0] rdata_b_o
);

  logic [7:0] mem_q [DDRAM_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i && (waddr_i < 7'(DDRAM_DEPTH))) mem_q[waddr_i] <= wdata_i;
    rdata_a_o <= (raddr_a_i < 7'(DDRAM_DEPTH)) ? mem_q[raddr_a_i] : CHAR_SPACE;
    rdata_b_o <= (raddr_b_i < 7'(DDRAM_DEPTH)) ? mem_q[raddr_b_i] : CHAR_SPACE;
  end

endmodule

// File: rtl/lcd1602_responder.sv
// LCD1602 (HD44780 subset) bus responder: synchronizes the host bus, executes
// instructions/data accesses on en falling edges and models busy timing.
//   state | meaning
//   IDLE  | ready, transactions execute
//   FILL  | writing spaces to all 80 DDRAM cells
//   WAIT  | busy down-counter running
module lcd1602_responder
  import lcd1602_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES  = 2000,
  parameter int unsigned CLEAR_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_data,
  output logic [7:0] lcd_dout,
  output logic       lcd_dout_oe,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [6:0] ac,
  output logic       busy,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_mode,
  output logic       cmd_pulse,
  output logic       data_pulse,
  output logic       err_busy
);

  localparam int unsigned FILL_CYCLES = DDRAM_DEPTH;

  logic [2:0]  en_s_q;
  logic [1:0]  rs_s_q, rw_s_q;
  logic [7:0]  data_s1_q, data_s2_q;
  logic        txn_pend_q, txn_rs_q, txn_rw_q;
  logic [7:0]  txn_data_q;
  lcd_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [6:0]  fill_q, fill_d;
  logic        fill_rst_q, fill_rst_d;
  logic [6:0]  ac_q, ac_d;
  logic        inc_q, inc_d, cg_q, cg_d;
  logic        disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
  logic        err_q, err_d;
  logic [7:0]  dout_q;
  logic        dout_oe_q;
  logic        we;
  logic [6:0]  waddr;
  logic [7:0]  wdata;
  logic [7:0]  bus_rdata;
  logic        en_fall;

  assign en_fall = en_s_q[2] & ~en_s_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      en_s_q     <= '0;
      rs_s_q     <= '0;
      rw_s_q     <= '0;
      data_s1_q  <= '0;
      data_s2_q  <= '0;
      txn_pend_q <= 1'b0;
      txn_rs_q   <= 1'b0;
      txn_rw_q   <= 1'b0;
      txn_data_q <= '0;
    end else begin
      en_s_q     <= {en_s_q[1:0], lcd_en};
      rs_s_q     <= {rs_s_q[0], lcd_rs};
      rw_s_q     <= {rw_s_q[0], lcd_rw};
      data_s1_q  <= lcd_data;
      data_s2_q  <= data_s1_q;
      txn_pend_q <= en_fall;
      if (en_fall) begin
        txn_rs_q   <= rs_s_q[1];
        txn_rw_q   <= rw_s_q[1];
        txn_data_q <= data_s2_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FILL;
      cnt_q      <= '0;
      fill_q     <= '0;
      fill_rst_q <= 1'b1;
      ac_q       <= LINE0_BASE;
      inc_q      <= 1'b1;
      cg_q       <= 1'b0;
      disp_q     <= 1'b0;
      cur_q      <= 1'b0;
      blink_q    <= 1'b0;
      err_q      <= 1'b0;
      dout_q     <= '0;
      dout_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
      fill_rst_q <= fill_rst_d;
      ac_q       <= ac_d;
      inc_q      <= inc_d;
      cg_q       <= cg_d;
      disp_q     <= disp_d;
      cur_q      <= cur_d;
      blink_q    <= blink_d;
      err_q      <= err_d;
      dout_oe_q  <= en_s_q[1] & rw_s_q[1];
      if (en_s_q[1] & rw_s_q[1]) dout_q <= rs_s_q[1] ? bus_rdata : {busy, ac_q};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    fill_rst_d = fill_rst_q;
    ac_d       = ac_q;
    inc_d      = inc_q;
    cg_d       = cg_q;
    disp_d     = disp_q;
    cur_d      = cur_q;
    blink_d    = blink_q;
    err_d      = err_q;
    we         = 1'b0;
    waddr      = fill_q;
    wdata      = CHAR_SPACE;
    cmd_pulse  = 1'b0;
    data_pulse = 1'b0;

    case (state_q)
      ST_FILL: begin
        we     = 1'b1;
        fill_d = fill_q + 7'd1;
        if (fill_q == 7'(DDRAM_DEPTH - 1)) begin
          fill_d = '0;
          // A power-on fill has no trailing wait; a clear pads out to CLEAR_CYCLES.
          if (fill_rst_q || (CLEAR_CYCLES <= FILL_CYCLES)) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CLEAR_CYCLES - FILL_CYCLES;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 32'd1;
        if (cnt_q <= 32'd1) state_d = ST_IDLE;
      end
      default: ;
    endcase

    if (txn_pend_q) begin
      if (txn_rw_q) begin
        if (txn_rs_q) ac_d = ac_step(ac_q, inc_q);
      end else if (state_q != ST_IDLE) begin
        err_d = 1'b1;
      end else if (txn_rs_q) begin
        data_pulse = 1'b1;
        we         = !cg_q && ac_valid(ac_q);
        waddr      = ddram_index(ac_q);
        wdata      = txn_data_q;
        ac_d       = ac_step(ac_q, inc_q);
        state_d    = ST_WAIT;
        cnt_d      = BUSY_CYCLES;
      end else begin
        cmd_pulse = 1'b1;
        state_d   = ST_WAIT;
        cnt_d     = BUSY_CYCLES;
        if (txn_data_q >= OP_DDRAM) begin
          ac_d = txn_data_q[6:0];
          cg_d = 1'b0;
        end else if (txn_data_q >= OP_CGRAM) begin
          cg_d = 1'b1;
        end else if (txn_data_q >= OP_FUNCSET) begin
          cg_d = cg_q;
        end else if (txn_data_q >= OP_SHIFT) begin
          if (!txn_data_q[3]) ac_d = ac_step(ac_q, txn_data_q[2]);
        end else if (txn_data_q >= OP_DISPLAY) begin
          disp_d  = txn_data_q[2];
          cur_d   = txn_data_q[1];
          blink_d = txn_data_q[0];
        end else if (txn_data_q >= OP_ENTRY) begin
          inc_d = txn_data_q[1];
        end else if (txn_data_q >= OP_HOME) begin
          ac_d = LINE0_BASE;
        end else if (txn_data_q == OP_CLEAR) begin
          ac_d       = LINE0_BASE;
          inc_d      = 1'b1;
          state_d    = ST_FILL;
          fill_d     = '0;
          fill_rst_d = 1'b0;
        end
      end
    end
  end

  lcd1602_ddram u_ddram (
    .clk       (clk),
    .we_i      (we),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .raddr_a_i (ddram_index(ac_q)),
    .rdata_a_o (bus_rdata),
    .raddr_b_i (ddram_index(rd_addr)),
    .rdata_b_o (rd_char)
  );

  assign busy        = (state_q != ST_IDLE);
  assign ac          = ac_q;
  assign inc_mode    = inc_q;
  assign disp_on     = disp_q;
  assign cursor_on   = cur_q;
  assign blink_on    = blink_q;
  assign err_busy    = err_q;
  assign lcd_dout    = dout_q;
  assign lcd_dout_oe = dout_oe_q;

endmodule
